inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Sequencer that walks the 64-entry, 39-bit instruction queue from a start address and presents decoded instructions to the execution datapath over a valid/ready handshake.
- Drives the queue's memread/address read port; the queue answers combinationally on readdata in the same cycle.
- Sits between the instruction queue and the register/ALU datapath. Owns the program counter, end-of-program detection, HALT decode and run statistics.

Parameters:
- ADDR_W, 6, width of the queue address and program counter.
- INST_W, 39, instruction width: opcode[38:36], rega[35:32], regb[31:28], imm[31:0].
- END_ADDR, 40, last queue address executed in a run.
- HALT_OP, 3'b111, opcode that stops sequencing without being issued.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a run (ignored while busy).
- start_addr  in  6  first queue address of the run, sampled on start.
- abort  in  1  terminates the run and returns to IDLE.
- memread  out  1  queue read enable.
- address  out  6  queue read address.
- readdata  in  39  queue read data, valid in the same cycle as memread/address.
- issue_valid  out  1  decoded instruction is valid.
- issue_ready  in  1  datapath accepts the instruction.
- opcode  out  3  instruction bits [38:36].
- rega  out  4  instruction bits [35:32].
- regb  out  4  instruction bits [31:28].
- imm  out  32  instruction bits [31:0].
- issue_addr  out  6  queue address of the presented instruction.
- busy  out  1  a run is in progress.
- done  out  1  the run finished normally; held until the next start.
- inst_count  out  7  instructions issued this run.
- stall_count  out  16  cycles with issue_valid=1 and issue_ready=0 this run; saturates at 16'hFFFF.

Behaviour:
- Reset values: every output is 0; state=IDLE; pc=0; instruction register IR=0.
- States are IDLE, FETCH, ISSUE and DONE.
- IDLE/DONE:
  - memread=0, issue_valid=0.
  - On start: pc<=start_addr, inst_count<=0, stall_count<=0, done<=0, then go to FETCH.
  - start while busy is ignored.
- FETCH (exactly 1 cycle):
  - memread=1, address=pc.
  - On the clock edge: IR<=readdata, issue_addr<=pc, pc<=pc+1 (6-bit).
  - If readdata[38:36]==HALT_OP, go to DONE with nothing issued. Otherwise go to ISSUE.
- ISSUE:
  - issue_valid=1. opcode, rega, regb, imm and issue_addr come from IR and stay stable until the handshake.
  - Prefetch: memread=1 and address=pc throughout ISSUE.
  - On issue_valid&&issue_ready:
    - inst_count increments.
    - If issue_addr==END_ADDR or issue_addr==63, go to DONE.
    - Else if readdata opcode==HALT_OP, go to DONE.
    - Else load IR<=readdata, issue_addr<=pc, pc<=pc+1 and stay in ISSUE. This gives back-to-back issue at 1 instruction per cycle.
  - Each cycle with valid and !ready increments stall_count (saturating).
- Latency: start at edge N, FETCH in cycle N+1, first issue_valid in cycle N+2.
- busy=1 in FETCH and ISSUE. done=1 in DONE.
- abort:
  - Highest priority in every state. It overrides start and a same-cycle handshake: that instruction is not counted.
  - Next state is IDLE, with issue_valid=0 and memread=0 in the following cycle.
  - done stays 0; the counters hold their values.
- start_addr > END_ADDR: the run continues to address 63, then goes to DONE. The pc never wraps within a run.
- Registered outputs are issue_valid, the decoded fields, issue_addr, busy, done and the counters. memread and address are combinational from state and pc.

Decomposition:
- Shared package nucore_pkg holds:
  - opcode constants: OP_RST=000, OP_STA=001, OP_STB=010, OP_ADD=011, OP_AND=110, OP_HALT=111;
  - field bit positions;
  - the state enum.
- Optional sub-module inst_field_decode: a purely combinational split of the 39-bit word into its fields, shared later with the execution unit.

Test Plan:
- Full program:
  - Stimulus: start, start_addr=0, issue_ready=1, END_ADDR=40.
  - Response: 41 issues on consecutive cycles, first in cycle N+2; address 21 gives opcode=011, rega=1, regb=1; then done=1, inst_count=41, stall_count=0.
- Backpressure:
  - Stimulus: issue_ready=0 for 5 cycles on the instruction at address 3.
  - Response: opcode=001, rega=3, imm=3 held stable; stall_count=5; nothing skipped or duplicated.
- HALT:
  - Stimulus: queue[12]=opcode 111, start_addr=10.
  - Response: addresses 10 and 11 issued, 12 never presented; done=1, inst_count=2.
- Tail at top of queue:
  - Stimulus: start_addr=50 (beyond END_ADDR).
  - Response: addresses 50..63 issued (14 zero-opcode instructions); then DONE, with no wrap to 0.
- Abort mid-run:
  - Stimulus: abort asserted in the same cycle as a handshake at address 5.
  - Response: next cycle is IDLE with issue_valid=0, memread=0, done=0; inst_count excludes address 5.
- Reset mid-operation:
  - Stimulus: rst_n low asynchronously during ISSUE.
  - Response: all outputs 0 immediately. After release, start re-runs from start_addr correctly.

Source files
------------

// File: rtl/nucore_pkg.sv
// -----------------------------------------------------------------------------
// nucore_pkg
// Shared definitions for the nucore instruction path: opcode encodings, bit
// positions of the fields inside a 39-bit queue word, and the state type of
// the fetch sequencer. Imported by the fetch controller, the field decoder and
// (later) the execution unit, so field layout lives in exactly one place.
// -----------------------------------------------------------------------------
package nucore_pkg;

  // Instruction opcodes (word bits [38:36])
  localparam logic [2:0] OP_RST  = 3'b000;
  localparam logic [2:0] OP_STA  = 3'b001;
  localparam logic [2:0] OP_STB  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Field positions inside the instruction word.
  // regb deliberately overlaps the top nibble of imm: the execution unit
  // picks whichever interpretation the opcode needs.
  localparam int OPCODE_MSB = 38;
  localparam int OPCODE_LSB = 36;
  localparam int REGA_MSB   = 35;
  localparam int REGA_LSB   = 32;
  localparam int REGB_MSB   = 31;
  localparam int REGB_LSB   = 28;
  localparam int IMM_MSB    = 31;
  localparam int IMM_LSB    = 0;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl_if
// Bundles the two buses of the fetch controller:
//   - queue read port : memread, address (to queue), readdata (from queue,
//                       combinational answer in the same cycle)
//   - issue port      : issue_valid / issue_ready handshake plus the decoded
//                       fields opcode, rega, regb, imm and issue_addr
// Modports:
//   master - the fetch controller (drives memread/address and the issue side)
//   slave  - the environment: queue plus execution datapath
// -----------------------------------------------------------------------------
interface inst_fetch_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int INST_W = 39
);

  // queue read port
  logic              memread;
  logic [ADDR_W-1:0] address;
  logic [INST_W-1:0] readdata;

  // issue port
  logic              issue_valid;
  logic              issue_ready;
  logic [2:0]        opcode;
  logic [3:0]        rega;
  logic [3:0]        regb;
  logic [31:0]       imm;
  logic [ADDR_W-1:0] issue_addr;

  modport master (
    output memread,
    output address,
    input  readdata,
    output issue_valid,
    input  issue_ready,
    output opcode,
    output rega,
    output regb,
    output imm,
    output issue_addr
  );

  modport slave (
    input  memread,
    input  address,
    output readdata,
    input  issue_valid,
    output issue_ready,
    input  opcode,
    input  rega,
    input  regb,
    input  imm,
    input  issue_addr
  );

endinterface

// File: rtl/inst_field_decode.sv
// -----------------------------------------------------------------------------
// inst_field_decode
// Purely combinational split of a queue word into its instruction fields.
// Kept as its own module so the execution unit can reuse the same layout.
// Ports:
//   word   in  INST_W  raw instruction word
//   opcode out 3       bits [38:36]
//   rega   out 4       bits [35:32]
//   regb   out 4       bits [31:28]
//   imm    out 32      bits [31:0]
// -----------------------------------------------------------------------------
module inst_field_decode
  import nucore_pkg::*;
#(
  parameter int INST_W = 39
) (
  input  logic [INST_W-1:0] word,
  output logic [2:0]        opcode,
  output logic [3:0]        rega,
  output logic [3:0]        regb,
  output logic [31:0]       imm
);

  assign opcode = word[OPCODE_MSB:OPCODE_LSB];
  assign rega   = word[REGA_MSB:REGA_LSB];
  assign regb   = word[REGB_MSB:REGB_LSB];
  assign imm    = word[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
// Walks the 64-entry instruction queue from a start address and presents each
// decoded instruction to the execution datapath over a valid/ready handshake.
// Owns the program counter, end-of-program detection, HALT decode and the
// per-run issue/stall statistics.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   one-cycle pulse starting a run (ignored while busy)
//   start_addr   in   first queue address, sampled with start
//   abort        in   ends the run immediately, highest priority
//   bus          if   master side of inst_fetch_ctrl_if (queue read port and
//                     issue handshake with decoded fields)
//   busy         out  run in progress (FETCH or ISSUE)
//   done         out  run finished normally, held until the next start
//   inst_count   out  instructions accepted by the datapath this run
//   stall_count  out  cycles with valid && !ready this run, saturating
// -----------------------------------------------------------------------------
module inst_fetch_ctrl
  import nucore_pkg::*;
#(
  parameter int                ADDR_W   = 6,
  parameter int                INST_W   = 39,
  parameter logic [ADDR_W-1:0] END_ADDR = ADDR_W'(40),
  parameter logic [2:0]        HALT_OP  = OP_HALT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic               abort,
  inst_fetch_ctrl_if.master  bus,
  output logic               busy,
  output logic               done,
  output logic [6:0]         inst_count,
  output logic [15:0]        stall_count
);

  localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] pc;
  logic [INST_W-1:0] ir;
  logic [ADDR_W-1:0] issue_addr_q;
  logic              issue_valid_q;
  logic              memread;
  logic [ADDR_W-1:0] address;
  logic              handshake;
  logic              last_addr;
  logic              rd_halt;

  // The word currently on readdata (fetch or prefetch) is a HALT
  assign rd_halt   = (bus.readdata[OPCODE_MSB:OPCODE_LSB] == HALT_OP);
  assign handshake = (state == ST_ISSUE) && bus.issue_ready;
  // Run ends at END_ADDR, or at the top of the queue for runs started past it,
  // so the pc never has to wrap inside a run
  assign last_addr = (issue_addr_q == END_ADDR) || (issue_addr_q == TOP_ADDR);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic; abort overrides start and any same-cycle handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_next = ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_next = rd_halt ? ST_DONE : ST_ISSUE;
        end
        ST_ISSUE: begin
          if (handshake && (last_addr || rd_halt)) begin
            state_next = ST_DONE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: the queue port reads at pc in FETCH and keeps prefetching
  // the next word throughout ISSUE so back-to-back issue needs no extra cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    memread = 1'b0;
    address = pc;
    if ((state == ST_FETCH) || (state == ST_ISSUE)) begin
      memread = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: pc, instruction register, presented address and statistics.
  // Counters only change while not aborting so an abort freezes them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= '0;
      ir           <= '0;
      issue_addr_q <= '0;
      inst_count   <= '0;
      stall_count  <= '0;
    end else if (!abort) begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            pc          <= start_addr;
            inst_count  <= '0;
            stall_count <= '0;
          end
        end
        ST_FETCH: begin
          ir           <= bus.readdata;
          issue_addr_q <= pc;
          pc           <= pc + ADDR_W'(1);
        end
        ST_ISSUE: begin
          if (bus.issue_ready) begin
            inst_count <= inst_count + 7'd1;
            if (!last_addr && !rd_halt) begin
              ir           <= bus.readdata;
              issue_addr_q <= pc;
              pc           <= pc + ADDR_W'(1);
            end
          end else if (stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered status flags, computed from the next state so they line up
  // with the state register without decode glitches
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_q <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      issue_valid_q <= (state_next == ST_ISSUE);
      busy          <= (state_next == ST_FETCH) || (state_next == ST_ISSUE);
      done          <= (state_next == ST_DONE);
    end
  end

  inst_field_decode #(
    .INST_W (INST_W)
  ) u_decode (
    .word   (ir),
    .opcode (bus.opcode),
    .rega   (bus.rega),
    .regb   (bus.regb),
    .imm    (bus.imm)
  );

  assign bus.memread     = memread;
  assign bus.address     = address;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_addr  = issue_addr_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl
// Scoreboard bench for inst_fetch_ctrl. A queue array model in the bench
// answers the read port; the expected issue sequence of every run is computed
// from the queue contents and pushed into a scoreboard, and a monitor process
// checks every presented instruction against the scoreboard head.
// -----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

  typedef struct {
    logic [5:0]  addr;
    logic [38:0] word;
  } exp_item_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  start_addr;
  logic        abort;
  logic        busy;
  logic        done;
  logic [6:0]  inst_count;
  logic [15:0] stall_count;

  logic [38:0] mem [64];
  int          stall_plan [64];
  exp_item_t   sb_q [$];
  int          exp_count;
  int          exp_stall;
  int          vectors;
  int          miscompares;
  int          stall_used;
  bit          prev_hs;

  inst_fetch_ctrl_if #(.ADDR_W(6), .INST_W(39)) bus ();

  inst_fetch_ctrl #(
    .ADDR_W   (6),
    .INST_W   (39),
    .END_ADDR (6'd40),
    .HALT_OP  (3'b111)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_addr  (start_addr),
    .abort       (abort),
    .bus         (bus.master),
    .busy        (busy),
    .done        (done),
    .inst_count  (inst_count),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue model: combinational answer to the read port
  assign bus.readdata = bus.memread ? mem[bus.address] : 39'd0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [38:0] make_word(input logic [2:0] op, input logic [3:0] ra,
                                            input logic [31:0] im);
    return {op, ra, im};
  endfunction

  // Program used by the directed runs: no HALT below END_ADDR, zero opcodes above
  task automatic load_default_program();
    logic [2:0] ops [5];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b011; ops[4] = 3'b110;
    for (int a = 0; a < 64; a++) begin
      if (a <= 40) mem[a] = make_word(ops[a % 5], 4'(a), {4'(a + 5), 22'd0, 6'(a)});
      else         mem[a] = make_word(3'b000, 4'(a), 32'(a * 3));
      stall_plan[a] = 0;
    end
    mem[3]  = make_word(3'b001, 4'd3, 32'd3);
    mem[21] = make_word(3'b011, 4'd1, 32'h1000_0000);
  endtask

  // Reference model: walk from the start address, stop before a HALT word,
  // after END_ADDR (40) or after the top address (63)
  task automatic build_expected(input int sa);
    exp_item_t it;
    int a;
    sb_q.delete();
    exp_count = 0;
    exp_stall = 0;
    a = sa;
    while (1) begin
      if (mem[a][38:36] == 3'b111) break;
      it.addr = 6'(a);
      it.word = mem[a];
      sb_q.push_back(it);
      exp_count++;
      exp_stall += stall_plan[a];
      if (a == 40 || a == 63) break;
      a++;
    end
  endtask

  // Launches a run and checks the FETCH cycle and first-issue latency
  task automatic applyStimulus(input int sa);
    build_expected(sa);
    @(negedge clk);
    start      = 1'b1;
    start_addr = 6'(sa);
    @(negedge clk);
    start = 1'b0;
    checkOutput("fetch_busy", busy, 1);
    checkOutput("fetch_memread", bus.memread, 1);
    checkOutput("fetch_address", bus.address, sa);
    checkOutput("fetch_valid", bus.issue_valid, 0);
    @(negedge clk);
    checkOutput("first_valid", bus.issue_valid, (exp_count > 0) ? 1 : 0);
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 500 && !done; i++) @(negedge clk);
    checkOutput("run_done", done, 1);
    checkOutput("run_busy", busy, 0);
    checkOutput("run_valid", bus.issue_valid, 0);
    checkOutput("run_inst_count", inst_count, exp_count);
    checkOutput("run_stall_count", stall_count, exp_stall);
    checkOutput("run_sb_left", sb_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    checkOutput("rst_memread", bus.memread, 0);
    checkOutput("rst_address", bus.address, 0);
    checkOutput("rst_valid", bus.issue_valid, 0);
    checkOutput("rst_opcode", bus.opcode, 0);
    checkOutput("rst_rega", bus.rega, 0);
    checkOutput("rst_regb", bus.regb, 0);
    checkOutput("rst_imm", bus.imm, 0);
    checkOutput("rst_issue_addr", bus.issue_addr, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_inst_count", inst_count, 0);
    checkOutput("rst_stall_count", stall_count, 0);
  endtask

  // Ready driver: holds ready low for the planned number of cycles on each
  // freshly presented instruction
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.issue_ready = 1'b1;
      stall_used      = 0;
      prev_hs         = 1'b0;
    end else begin
      if (prev_hs || !bus.issue_valid) stall_used = 0;
      if (bus.issue_valid && stall_used < stall_plan[bus.issue_addr]) begin
        bus.issue_ready = 1'b0;
        stall_used++;
      end else begin
        bus.issue_ready = 1'b1;
      end
      prev_hs = bus.issue_valid && bus.issue_ready && !abort;
    end
  end

  // Monitor: every presented cycle must match the scoreboard head; the head
  // retires only on a handshake that abort does not cancel
  always @(negedge clk) begin
    #1;
    if (rst_n && bus.issue_valid) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_issue_addr", bus.issue_addr, 64'hFFFF);
      end else begin
        checkOutput("issue_addr", bus.issue_addr, sb_q[0].addr);
        checkOutput("opcode", bus.opcode, sb_q[0].word[38:36]);
        checkOutput("rega", bus.rega, sb_q[0].word[35:32]);
        checkOutput("regb", bus.regb, sb_q[0].word[31:28]);
        checkOutput("imm", bus.imm, sb_q[0].word[31:0]);
        if (bus.issue_ready && !abort) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    bit found;
    int sa;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    start_addr  = 6'd0;
    load_default_program();
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] full program from 0");
    applyStimulus(0);
    wait_done();

    $display("[TB] backpressure at address 3");
    stall_plan[3] = 5;
    applyStimulus(0);
    wait_done();
    stall_plan[3] = 0;

    $display("[TB] HALT at address 12");
    mem[12] = make_word(3'b111, 4'd2, 32'd12);
    applyStimulus(10);
    wait_done();
    load_default_program();

    $display("[TB] tail from 50");
    applyStimulus(50);
    wait_done();

    $display("[TB] abort with handshake at address 5");
    applyStimulus(0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.issue_valid && bus.issue_addr == 6'd5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("abort_target_seen", found, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_valid", bus.issue_valid, 0);
    checkOutput("abort_memread", bus.memread, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_inst_count", inst_count, 5);
    checkOutput("abort_stall_count", stall_count, 0);
    sb_q.delete();

    $display("[TB] reset during ISSUE");
    applyStimulus(20);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(7);
    wait_done();

    $display("[TB] randomized runs");
    for (int r = 0; r < 24; r++) begin
      for (int a = 0; a < 64; a++) begin
        logic [2:0] op;
        op = 3'($urandom_range(0, 7));
        if (op == 3'b111 && $urandom_range(0, 3) != 0) op = 3'b011;
        if (op == 3'b100 || op == 3'b101) op = 3'b010;
        mem[a]        = make_word(op, 4'($urandom), 32'($urandom));
        stall_plan[a] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 3);
      end
      sa = $urandom_range(0, 63);
      applyStimulus(sa);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
        if (busy) begin
          start      = 1'b1;
          start_addr = 6'($urandom_range(0, 63));
          @(negedge clk);
          start = 1'b0;
        end
      end
      wait_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
